// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the requesters, the write-port arbiter and the FIFO write side.
// The master side drives requests, data and the FIFO full flag; the arbiter is the slave.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 3
);
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] data;
    logic               fifo_full;
    logic               fifo_wen;
    logic [DW-1:0]      fifo_din;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               busy;

    modport master (
        output req, data, fifo_full,
        input  fifo_wen, fifo_din, gnt, ack, busy
    );

    modport slave (
        input  req, data, fifo_full,
        output fifo_wen, fifo_din, gnt, ack, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters.
// Define FIFO_ARB_BURST_EN to hold a grant for up to BURST_LEN beats; otherwise one beat per grant.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 3,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          r_state;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_rr_ptr;
    logic [NREQ-1:0] r_gnt;
    logic            r_busy;
`ifdef FIFO_ARB_BURST_EN
    logic [3:0]      r_beat_cnt;
`endif

    logic [IW-1:0]   w_scan_start;
    logic [IW-1:0]   w_winner;
    logic            w_found;
    logic            w_own_req;
    logic            w_accept;
    logic            w_last;
    logic            w_release;

    // On release the scan starts just past the owner, so the old owner ranks last.
    always_comb begin
        w_scan_start = r_rr_ptr;
        if (r_state == StGrant) begin
            w_scan_start = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
        end
    end

    always_comb begin : p_scan
        int unsigned idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (int'(w_scan_start) + k) % NREQ;
            if (!w_found && bus.req[idx]) begin
                w_found  = 1'b1;
                w_winner = IW'(idx);
            end
        end
    end

    assign w_own_req = bus.req[r_owner];
    assign w_accept  = (r_state == StGrant) && w_own_req && !bus.fifo_full;

`ifdef FIFO_ARB_BURST_EN
    assign w_last = (r_beat_cnt == 4'(BURST_LEN - 1));
`else
    assign w_last = 1'b1;
`endif

    assign w_release = (r_state == StGrant) && (!w_own_req || (w_accept && w_last));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
            r_beat_cnt <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_state    <= StGrant;
                        r_owner    <= w_winner;
                        r_gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
                        r_busy     <= 1'b1;
`ifdef FIFO_ARB_BURST_EN
                        r_beat_cnt <= '0;
`endif
                    end
                end
                StGrant: begin
                    if (w_release) begin
                        r_rr_ptr <= w_scan_start;
                        if (w_found) begin
                            r_owner    <= w_winner;
                            r_gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
`ifdef FIFO_ARB_BURST_EN
                            r_beat_cnt <= '0;
`endif
                        end else begin
                            r_state <= StIdle;
                            r_gnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end
`ifdef FIFO_ARB_BURST_EN
                    else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                    end
`endif
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.fifo_din = '0;
        if (r_state == StGrant) begin
            bus.fifo_din = bus.data[int'(r_owner) * int'(DW) +: DW];
        end
    end

    assign bus.fifo_wen = w_accept;
    assign bus.ack      = w_accept ? r_gnt : '0;
    assign bus.gnt      = r_gnt;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; expectations follow the effective burst length
// (4 with FIFO_ARB_BURST_EN, otherwise 1).
module tb_fifo_wr_arbiter;
`ifdef FIFO_ARB_BURST_EN
    localparam int BL = 4;
`else
    localparam int BL = 1;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fifo_wr_arbiter_if #(.NREQ(4), .DW(3)) bus ();

    fifo_wr_arbiter #(.NREQ(4), .DW(3), .BURST_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst           = 1'b0;
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin : p_main
        int         own;
        logic [3:0] eg;
        errors        = 0;
        checks        = 0;
        rst           = 1'b0;
        bus.req       = '0;
        bus.data      = '0;
        bus.fifo_full = 1'b0;
        #2;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_wen", 32'(bus.fifo_wen), 0);
        chk("rst_din", 32'(bus.fifo_din), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        do_reset();

        // Idle with no requests
        for (int c = 0; c < 5; c++) begin
            tick();
            #2;
            chk("idle_gnt", 32'(bus.gnt), 0);
            chk("idle_wen", 32'(bus.fifo_wen), 0);
            chk("idle_busy", 32'(bus.busy), 0);
        end

        // Two requesters alternate in bursts of BL
        bus.data = {3'd0, 3'd0, 3'd2, 3'd5};
        bus.req  = 4'b0011;
        #2;
        chk("b2_pre_gnt", 32'(bus.gnt), 0);
        for (int c = 0; c < 3 * 4; c++) begin
            tick();
            #2;
            own = (c / BL) % 2;
            eg  = 4'b0001 << own;
            chk("b2_gnt", 32'(bus.gnt), 32'(eg));
            chk("b2_wen", 32'(bus.fifo_wen), 1);
            chk("b2_din", 32'(bus.fifo_din), (own == 0) ? 5 : 2);
            chk("b2_ack", 32'(bus.ack), 32'(eg));
            chk("b2_busy", 32'(bus.busy), 1);
        end

        // All four requesting: grant rotates 0,1,2,3,0
        do_reset();
        bus.req = 4'b1111;
        for (int c = 0; c < 5 * BL; c++) begin
            tick();
            #2;
            own = (c / BL) % 4;
            chk("rr_gnt", 32'(bus.gnt), 32'(4'b0001 << own));
            chk("rr_wen", 32'(bus.fifo_wen), 1);
        end

        // Full stall after the first beat of owner 2
        do_reset();
        bus.data = {3'd6, 3'd3, 3'd0, 3'd0};
        bus.req  = 4'b1100;
        tick();
        #2;
        chk("st_first_gnt", 32'(bus.gnt), 32'(4'b0100));
        chk("st_first_wen", 32'(bus.fifo_wen), 1);
        chk("st_first_din", 32'(bus.fifo_din), 3);
        tick();
        bus.fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) tick();
            #2;
            chk("st_stall_wen", 32'(bus.fifo_wen), 0);
            chk("st_stall_ack", 32'(bus.ack), 0);
            chk("st_stall_gnt", 32'(bus.gnt), (BL > 1) ? 32'(4'b0100) : 32'(4'b1000));
        end
        tick();
        bus.fifo_full = 1'b0;
        for (int k = 0; k < BL; k++) begin
            if (k != 0) tick();
            #2;
            own = (k < BL - 1) ? 2 : 3;
            chk("st_res_gnt", 32'(bus.gnt), 32'(4'b0001 << own));
            chk("st_res_wen", 32'(bus.fifo_wen), 1);
            chk("st_res_din", 32'(bus.fifo_din), (own == 2) ? 3 : 6);
        end

        // Early release: owner 1 drops after 2 beats, 3 takes over
        do_reset();
        bus.data = {3'd7, 3'd4, 3'd1, 3'd0};
        bus.req  = 4'b0010;
        for (int c = 0; c < 2; c++) begin
            tick();
            #2;
            chk("er_gnt", 32'(bus.gnt), 32'(4'b0010));
            chk("er_wen", 32'(bus.fifo_wen), 1);
            chk("er_din", 32'(bus.fifo_din), 1);
        end
        tick();
        bus.req = 4'b1000;
        #2;
        chk("er_drop_wen", 32'(bus.fifo_wen), 0);
        tick();
        #2;
        chk("er_next_gnt", 32'(bus.gnt), 32'(4'b1000));
        chk("er_next_wen", 32'(bus.fifo_wen), 1);
        chk("er_next_din", 32'(bus.fifo_din), 7);

        // Pointer after releasing owner 1 sits at 2, so 2 beats 3 and 0
        do_reset();
        bus.req = 4'b0010;
        tick();
        tick();
        tick();
        bus.req = 4'b1101;
        #2;
        chk("ptr_drop_wen", 32'(bus.fifo_wen), 0);
        tick();
        #2;
        chk("ptr_gnt", 32'(bus.gnt), 32'(4'b0100));
        chk("ptr_din", 32'(bus.fifo_din), 4);

        // Asynchronous reset in the middle of a burst
        do_reset();
        bus.req = 4'b1111;
        tick();
        tick();
        #2;
        chk("ar_pre_wen", 32'(bus.fifo_wen), 1);
        rst = 1'b0;
        #1;
        chk("ar_wen", 32'(bus.fifo_wen), 0);
        chk("ar_gnt", 32'(bus.gnt), 0);
        chk("ar_ack", 32'(bus.ack), 0);
        chk("ar_busy", 32'(bus.busy), 0);
        chk("ar_din", 32'(bus.fifo_din), 0);
        tick();
        rst = 1'b1;
        #2;
        chk("ar_idle_gnt", 32'(bus.gnt), 0);
        tick();
        #2;
        chk("ar_first_gnt", 32'(bus.gnt), 32'(4'b0001));
        chk("ar_first_wen", 32'(bus.fifo_wen), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
